// File: rtl/irq_source_ctrl_if.sv
// Configuration bus, source lines and core interrupt handshake for irq_source_ctrl.
interface irq_source_ctrl_if;
    logic [31:0] src_i;
    logic        cfg_we_i;
    logic        cfg_re_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;
    logic [31:0] irq_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;
    logic        spurious_ack_o;

    modport master (
        output src_i, cfg_we_i, cfg_re_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_id_i,
        input  cfg_rdata_o, irq_o, spurious_ack_o
    );

    modport slave (
        input  src_i, cfg_we_i, cfg_re_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_id_i,
        output cfg_rdata_o, irq_o, spurious_ack_o
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: level/edge capture, enable masking, ack and W1C clearing.
// Define IRQ_SRC_SYNC_EN to put a 2-flop synchronizer on src_i (3-cycle latency instead of 2).
module irq_source_ctrl #(
    parameter logic [31:0] LEGAL_MASK = 32'hFFFF_0888
) (
    input logic            clk_i,
    input logic            rst_n,
    irq_source_ctrl_if.slave bus
);

`ifdef IRQ_SRC_SYNC_EN
    localparam int FILL_W = 3;
    logic [31:0] src_p0;
`else
    localparam int FILL_W = 2;
`endif

    logic [31:0]       s_p1;
    logic [31:0]       s_p2;
    logic [FILL_W-1:0] fill_q;
    logic              hist_vld;
    logic [31:0]       enable_q;
    logic [31:0]       edge_q;
    logic [31:0]       pend_q;
    logic [31:0]       pend_nxt;
    logic [31:0]       rdata_q;
    logic [31:0]       rd_mux;
    logic              spur_q;
    logic [31:0]       irq_int;
    logic [31:0]       set_vec;
    logic [31:0]       clr_vec;
    logic [31:0]       chg_vec;
    logic [31:0]       wdata_legal;
    logic              ack_hit;

    // Input stage: sampled source s_p1 and its one-cycle history s_p2
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
`ifdef IRQ_SRC_SYNC_EN
            src_p0 <= '0;
`endif
            s_p1   <= '0;
            s_p2   <= '0;
            fill_q <= '0;
        end else begin
`ifdef IRQ_SRC_SYNC_EN
            src_p0 <= bus.src_i;
            s_p1   <= src_p0;
`else
            s_p1   <= bus.src_i;
`endif
            s_p2   <= s_p1;
            fill_q <= {fill_q[FILL_W-2:0], 1'b1};
        end
    end

    // s_p2 only holds a real sample once the input pipeline has filled after reset,
    // so a line already high at reset release is taken as the baseline, not an edge.
    assign hist_vld = fill_q[FILL_W-1];

    assign irq_int     = pend_q & enable_q & LEGAL_MASK;
    assign wdata_legal = bus.cfg_wdata_i & LEGAL_MASK;
    assign ack_hit     = bus.irq_ack_i & irq_int[bus.irq_id_i];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        chg_vec = '0;
        set_vec = edge_q & s_p1 & ~s_p2 & {32{hist_vld}};
        if (ack_hit) begin
            clr_vec = clr_vec | (32'(1) << bus.irq_id_i);
        end
        if (bus.cfg_we_i && bus.cfg_addr_i == 2'd2) begin
            clr_vec = clr_vec | bus.cfg_wdata_i;
        end
        clr_vec = clr_vec & edge_q;
        if (bus.cfg_we_i && bus.cfg_addr_i == 2'd1) begin
            chg_vec = wdata_legal ^ edge_q;
        end
        // Set beats clear so no edge is lost; a mode change always empties the bit.
        pend_nxt = (edge_q & ((pend_q & ~clr_vec) | set_vec)) | (~edge_q & s_p1);
        pend_nxt = pend_nxt & ~chg_vec & LEGAL_MASK;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.cfg_addr_i)
            2'd0:    rd_mux = enable_q;
            2'd1:    rd_mux = edge_q;
            2'd2:    rd_mux = pend_q;
            default: rd_mux = s_p1;
        endcase
    end

    // State stage: configuration, pending, read-back and spurious flag
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            rdata_q  <= '0;
            spur_q   <= 1'b0;
        end else begin
            if (bus.cfg_we_i && bus.cfg_addr_i == 2'd0) begin
                enable_q <= wdata_legal;
            end
            if (bus.cfg_we_i && bus.cfg_addr_i == 2'd1) begin
                edge_q <= wdata_legal;
            end
            pend_q <= pend_nxt;
            spur_q <= bus.irq_ack_i & ~irq_int[bus.irq_id_i];
            if (bus.cfg_re_i) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign bus.irq_o          = irq_int;
    assign bus.cfg_rdata_o    = rdata_q;
    assign bus.spurious_ack_o = spur_q;

endmodule

// File: doc/irq_source_ctrl.md
IRQ_SOURCE_CTRL -- requirements
Module: irq_source_ctrl

Interface
REQ-001 Parameter LEGAL_MASK, default 32'hFFFF_0888, marks implementable interrupt lines; all other bits are reserved.
REQ-002 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-003 clk_i  input  1  sole clock; all flops sample on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 src_i  input  32  raw interrupt source lines, which may be asynchronous to clk_i.
REQ-006 cfg_we_i  input  1  configuration write strobe.
REQ-007 cfg_re_i  input  1  configuration read strobe.
REQ-008 cfg_addr_i  input  2  register select: 0=ENABLE, 1=EDGE, 2=PENDING, 3=RAW.
REQ-009 cfg_wdata_i  input  32  write data.
REQ-010 cfg_rdata_o  output  32  read data, registered.
REQ-011 irq_o  output  32  interrupt lines to the core irq_i.
REQ-012 irq_ack_i  input  1  core acknowledge pulse.
REQ-013 irq_id_i  input  5  index of the acknowledged interrupt, valid only when irq_ack_i=1.
REQ-014 spurious_ack_o  output  1  one-cycle pulse flagging an acknowledge of a non-asserted line.

Function
REQ-015 The sampled source s SHALL be src_i after the input stage (1 flop, or 2 flops under REQ-032); s_d SHALL be s delayed by one cycle.
REQ-016 ENABLE and EDGE SHALL be read/write registers; written bits SHALL be ANDed with LEGAL_MASK, and reserved bits SHALL always read 0.
REQ-017 For a level source (EDGE[k]=0), the block SHALL update pending[k] to s[k] every cycle.
REQ-018 For an edge source (EDGE[k]=1), the block SHALL set pending[k] when s[k] & ~s_d[k], and pending[k] SHALL hold until cleared.
REQ-019 irq_o SHALL equal pending & ENABLE & LEGAL_MASK, decoded combinationally from flops only.
REQ-020 Latency from a src_i rise to irq_o rise SHALL be 2 cycles (3 cycles with REQ-032).
REQ-021 When irq_ack_i=1 with irq_id_i=k, EDGE[k]=1 and irq_o[k]=1, the block SHALL clear pending[k] on the next edge; an acknowledge of a level source SHALL leave its state unchanged.
REQ-022 When irq_ack_i=1 and irq_o[irq_id_i]=0, the block SHALL pulse spurious_ack_o for exactly one cycle, starting the next cycle, and SHALL change no state.
REQ-023 Writing PENDING (addr 2) SHALL clear each edge-mode pending bit whose wdata bit is 1 (write-1-to-clear); level-mode bits SHALL be unaffected.
REQ-024 A write to RAW (addr 3) SHALL be ignored.
REQ-025 When a set event and a clear event (acknowledge or W1C) hit the same bit in the same cycle, set SHALL win, so no edge is lost.
REQ-026 Any write that changes EDGE[k] SHALL clear pending[k]; a level source then refills on the following cycle.
REQ-027 cfg_rdata_o SHALL present the selected register one cycle after cfg_re_i and SHALL hold that value until the next read.
REQ-028 A simultaneous cfg_re_i and cfg_we_i to the same address SHALL return the pre-write value.

Reset
REQ-029 On rst_n low, all flops SHALL clear to 0 immediately: ENABLE, EDGE, pending, s, s_d, cfg_rdata_o and spurious_ack_o.
REQ-030 irq_o SHALL be 0 while reset is asserted.
REQ-031 A source already high at reset release SHALL NOT register as an edge.

Configuration
REQ-032 Macro IRQ_SRC_SYNC_EN:
- Defined: src_i passes through a 2-flop synchronizer, giving 3-cycle latency.
- Undefined: src_i passes through a single sampling flop, giving 2-cycle latency.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-033 ENABLE=0x0000_0800, EDGE=0, src_i[11] high at cycle 0 -> irq_o=0x0000_0800 at cycle 2 (cycle 3 with sync); src_i[11] low -> irq_o=0 two cycles later.
REQ-034 EDGE=ENABLE=0x0001_0000, 1-cycle pulse on src_i[16] -> irq_o[16] stays high; irq_ack_i with id 16 -> irq_o[16]=0 the next cycle and spurious_ack_o=0.
REQ-035 irq_ack_i with id 7 while irq_o=0 -> spurious_ack_o high for exactly one cycle; no register changes.
REQ-036 Write ENABLE=0xFFFF_FFFF, then read addr 0 -> cfg_rdata_o=0xFFFF_0888 one cycle after the read strobe.
REQ-037 Edge source 20 pending, new src_i[20] edge detected in the same cycle as its acknowledge -> pending[20] remains 1; rst_n asserted mid-pending -> irq_o=0 immediately and all reads return 0 after release.
